pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MiniMIPS32 core. It merges stall requests from the ID, EXE (divider), IF (ibus) and MEM (dbus) stages into the per-register stall bus consumed by all pipeline registers. It sequences the multi-cycle divider with a start/ready handshake. It converts MEM-stage exceptions and ERET into a one-cycle flush plus a redirect PC for the fetch stage.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions except ERET
PERF_W, 32, width of the optional stall-cycle counter

Ports:
cpu_clk_50M  in  1  core clock
cpu_rst_n  in  1  asynchronous active-low reset
stallreq_id  in  1  load-use hazard detected in ID
stallreq_if  in  1  ibus not ready
stallreq_mem  in  1  dbus not ready
exe_is_div  in  1  EXE holds DIV/DIVU
div_ready  in  1  divider result valid (1-cycle pulse)
exc_valid  in  1  MEM-stage exception or ERET, exccode != EXC_NONE
exc_is_eret  in  1  the exception is ERET
cp0_epc  in  32  EPC value
stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EXE, [3]=EXE/MEM, [4]=MEM/WB, [5]=WB; 1=STOP
div_start  out  1  one-cycle divider launch
div_cancel  out  1  one-cycle divider abort
flush  out  1  clears all pipeline registers
flush_pc  out  32  redirect target, valid while flush=1
perf_stall_cnt  out  PERF_W  only with PIPE_PERF_EN

Behaviour:
- The reset is asynchronous and active-low on cpu_rst_n. Reset state is IDLE. All of stall, div_start, div_cancel, flush, flush_pc and perf_stall_cnt reset to 0.
- FSM states:
  - IDLE: normal operation.
  - DIV_BUSY: divider running.
  - EXC_WAIT: exception captured, waiting for dbus.
  - FLUSH: one-cycle flush.
- stall is combinational from state and requests. The highest-priority active source wins:
  - 1. state==FLUSH: 6'b000000.
  - 2. stallreq_mem or state==EXC_WAIT: 6'b011111.
  - 3. state==DIV_BUSY, or IDLE with exe_is_div and no div_done flag: 6'b001111.
  - 4. stallreq_id: 6'b000111. This makes ID/EXE insert a bubble.
  - 5. stallreq_if: 6'b000011.
  - 6. Otherwise 6'b000000.
- Divider sequencing:
  - In IDLE, exe_is_div=1 and div_done=0 with no higher-priority stall: div_start=1 for that cycle, and the next state is DIV_BUSY.
  - In DIV_BUSY, div_ready=1: the next state is IDLE, and the registered div_done flag is set. stall drops in the same cycle as div_ready so the DIV advances.
  - div_done clears on the first cycle in which stall[3]=0. This prevents a relaunch of the same DIV.
  - div_ready in any state other than DIV_BUSY is ignored.
- Exception capture:
  - exc_valid in IDLE or DIV_BUSY captures the target into a register: cp0_epc if exc_is_eret, else EXC_VECTOR.
  - If captured in DIV_BUSY, div_cancel=1 for that cycle.
  - Next state is FLUSH when stallreq_mem=0, else EXC_WAIT.
- EXC_WAIT: holds the captured target and ignores further exc_valid. It moves to FLUSH on the first cycle with stallreq_mem=0.
- FLUSH: flush=1 and flush_pc=captured target for exactly one cycle, then IDLE. div_done clears. Inputs are ignored in this cycle.
- flush and flush_pc are registered outputs: one cycle of latency from exception capture when dbus is idle.
- Simultaneous events:
  - exc_valid with div_ready: the exception wins, and div_cancel is not asserted.
  - exc_valid with exe_is_div in IDLE: no div_start.
- Reset mid-operation returns to IDLE immediately. The divider is expected to be reset by the same cpu_rst_n.

Optional Feature:
PIPE_PERF_EN.
- Defined: perf_stall_cnt increments by 1 every cycle in which stall[0]=1. It wraps modulo 2^PERF_W and clears only on reset.
- Undefined: the port and counter are absent.

Decomposition:
- Shared defines file additions:
  - STALL_BUS [5:0]
  - STOP=1'b1 and NOSTOP=1'b0
  - state encodings PC_IDLE, PC_DIV_BUSY, PC_EXC_WAIT, PC_FLUSH
  - EXC_VECTOR default
- No sub-module. The FSM and the optional counter fit in one module. A separate stall_prio function is acceptable.

Test Plan:
- stallreq_id=1 for 1 cycle in IDLE -> stall=6'b000111 that cycle; next cycle 6'b000000.
- exe_is_div=1, div_ready after 33 cycles -> div_start pulse in cycle 0; stall=6'b001111 for cycles 0..33 exclusive; stall=0 in the div_ready cycle; no second div_start.
- exc_valid=1, exc_is_eret=0, stallreq_mem=0 -> next cycle flush=1, flush_pc=32'hBFC0_0380, stall=0; then IDLE.
- exc_valid=1 with stallreq_mem=1 held 3 cycles, eret, cp0_epc=32'h8000_1234 -> stall=6'b011111 for those cycles; then a single flush with flush_pc=32'h8000_1234.
- exc_valid during DIV_BUSY -> div_cancel pulse; flush the following cycle; no later div_start without a fresh exe_is_div.
- PIPE_PERF_EN defined: 5 stalled cycles -> perf_stall_cnt=5; assert cpu_rst_n=0 mid-DIV_BUSY -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MiniMIPS32 pipeline sequencer:
// stall bus encoding, FSM states, default exception vector, stall priority.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W   = 6;
  localparam int unsigned PC_PERF_W = 32;
  localparam logic [31:0] PC_EXC_VECTOR = 32'hBFC0_0380;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // [0]=PC, [1]=IF/ID, [2]=ID/EXE, [3]=EXE/MEM, [4]=MEM/WB, [5]=WB
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = {6{NOSTOP}};
  localparam stall_bus_t STALL_MEM  = {NOSTOP, {5{STOP}}};
  localparam stall_bus_t STALL_DIV  = {{2{NOSTOP}}, {4{STOP}}};
  localparam stall_bus_t STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
  localparam stall_bus_t STALL_IF   = {{4{NOSTOP}}, {2{STOP}}};

  typedef enum logic [1:0] {
    PC_IDLE     = 2'd0,
    PC_DIV_BUSY = 2'd1,
    PC_EXC_WAIT = 2'd2,
    PC_FLUSH    = 2'd3
  } pc_state_t;

  // Highest-priority stall source wins; div_ready releases the divider stall in its own cycle.
  function automatic stall_bus_t stall_prio(
    input pc_state_t st,
    input logic      req_mem,
    input logic      req_id,
    input logic      req_if,
    input logic      exe_is_div,
    input logic      div_done,
    input logic      div_ready
  );
    stall_bus_t s;
    if (st == PC_FLUSH)
      s = STALL_NONE;
    else if (req_mem || st == PC_EXC_WAIT)
      s = STALL_MEM;
    else if ((st == PC_DIV_BUSY && !div_ready) ||
             (st == PC_IDLE && exe_is_div && !div_done))
      s = STALL_DIV;
    else if (req_id)
      s = STALL_ID;
    else if (req_if)
      s = STALL_IF;
    else
      s = STALL_NONE;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, divider start/cancel handshake, exception flush/redirect.
// Optional stall-cycle counter enabled by defining PIPE_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = PC_EXC_VECTOR
`ifdef PIPE_PERF_EN
  ,
  parameter int unsigned PERF_W = PC_PERF_W
`endif
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stallreq_id,
  input  logic        stallreq_if,
  input  logic        stallreq_mem,
  input  logic        exe_is_div,
  input  logic        div_ready,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        div_start,
  output logic        div_cancel,
  output logic        flush,
  output logic [31:0] flush_pc
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

  pc_state_t   state, state_next;
  logic        div_done, div_done_next;
  logic [31:0] exc_target, target_next;
  stall_bus_t  stall_c;
  logic        div_start_c, div_cancel_c;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= PC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    div_done_next = div_done;
    target_next   = exc_target;
    div_start_c   = 1'b0;
    div_cancel_c  = 1'b0;
    stall_c       = stall_prio(state, stallreq_mem, stallreq_id, stallreq_if,
                               exe_is_div, div_done, div_ready);

    // The completed DIV has left EXE once EXE/MEM is allowed to advance.
    if (stall_c[3] == NOSTOP) div_done_next = 1'b0;

    case (state)
      PC_IDLE: begin
        if (exc_valid) begin
          target_next = exc_is_eret ? cp0_epc : EXC_VECTOR;
          state_next  = stallreq_mem ? PC_EXC_WAIT : PC_FLUSH;
        end else if (exe_is_div && !div_done && !stallreq_mem) begin
          div_start_c = 1'b1;
          state_next  = PC_DIV_BUSY;
        end
      end
      PC_DIV_BUSY: begin
        if (exc_valid) begin
          target_next  = exc_is_eret ? cp0_epc : EXC_VECTOR;
          div_cancel_c = !div_ready;
          state_next   = stallreq_mem ? PC_EXC_WAIT : PC_FLUSH;
        end else if (div_ready) begin
          div_done_next = 1'b1;
          state_next    = PC_IDLE;
        end
      end
      PC_EXC_WAIT: begin
        if (!stallreq_mem) state_next = PC_FLUSH;
      end
      PC_FLUSH: begin
        div_done_next = 1'b0;
        state_next    = PC_IDLE;
      end
      default: state_next = PC_IDLE;
    endcase

    // Combinational outputs are held quiet while reset is asserted.
    stall      = cpu_rst_n ? stall_c : STALL_NONE;
    div_start  = cpu_rst_n & div_start_c;
    div_cancel = cpu_rst_n & div_cancel_c;
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      div_done   <= 1'b0;
      exc_target <= 32'h0;
      flush      <= 1'b0;
      flush_pc   <= 32'h0;
    end else begin
      div_done   <= div_done_next;
      exc_target <= target_next;
      flush      <= (state_next == PC_FLUSH);
      flush_pc   <= (state_next == PC_FLUSH) ? target_next : 32'h0;
    end
  end

`ifdef PIPE_PERF_EN
  // Counts cycles in which the PC is held; wraps naturally.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_stall_cnt <= '0;
    end else if (stall[0] == STOP) begin
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs change 1ns after the rising
// edge and outputs are sampled on the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stallreq_id, stallreq_if, stallreq_mem;
  logic        exe_is_div, div_ready, exc_valid, exc_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        div_start, div_cancel, flush;
  logic [31:0] flush_pc;
`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_ctrl dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .stallreq_id (stallreq_id),
    .stallreq_if (stallreq_if),
    .stallreq_mem(stallreq_mem),
    .exe_is_div  (exe_is_div),
    .div_ready   (div_ready),
    .exc_valid   (exc_valid),
    .exc_is_eret (exc_is_eret),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .div_start   (div_start),
    .div_cancel  (div_cancel),
    .flush       (flush),
    .flush_pc    (flush_pc)
`ifdef PIPE_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    stallreq_id = 0; stallreq_if = 0; stallreq_mem = 0;
    exe_is_div = 0; div_ready = 0; exc_valid = 0; exc_is_eret = 0;
    cp0_epc = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    exe_is_div = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if (stall !== 6'b000000 || div_start !== 1'b0 || div_cancel !== 1'b0 ||
        flush !== 1'b0 || flush_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset: stall=%b start=%b cancel=%b flush=%b pc=%h, want all zero",
               stall, div_start, div_cancel, flush, flush_pc);
    end
    next_cycle();
    idle_inputs();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (stall !== 6'b000000 || flush !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: stall=%b flush=%b, want 000000/0", stall, flush);
    end
  endtask

  task automatic test_stall_prio();
    logic [5:0] exp [4];
    logic [3:0] req [4];  // {mem, id, if, unused}
    req[0] = 4'b0100; exp[0] = 6'b000111;
    req[1] = 4'b0000; exp[1] = 6'b000000;
    req[2] = 4'b0010; exp[2] = 6'b000011;
    req[3] = 4'b1110; exp[3] = 6'b011111;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      stallreq_mem = req[i][3]; stallreq_id = req[i][2]; stallreq_if = req[i][1];
      @(negedge clk);
      total++;
      if (stall !== exp[i]) begin
        bad++;
        $display("FAIL stall_prio[%0d]: stall=%b want %b", i, stall, exp[i]);
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_div();
    int errs;
    errs = 0;
    for (int c = 0; c <= 35; c++) begin
      next_cycle();
      exe_is_div = (c <= 34);
      div_ready  = (c == 33);
      @(negedge clk);
      total++;
      if (c == 0) begin
        if (div_start !== 1'b1 || stall !== 6'b001111) begin
          bad++;
          $display("FAIL div_launch: start=%b stall=%b want 1/001111", div_start, stall);
        end
      end else if (c < 33) begin
        if (div_start !== 1'b0 || stall !== 6'b001111) begin
          bad++;
          $display("FAIL div_busy[%0d]: start=%b stall=%b want 0/001111", c, div_start, stall);
        end
      end else begin
        if (div_start !== 1'b0 || stall !== 6'b000000 || div_cancel !== 1'b0) begin
          bad++;
          $display("FAIL div_done[%0d]: start=%b stall=%b cancel=%b want 0/000000/0",
                   c, div_start, stall, div_cancel);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_exc_vector();
    next_cycle();
    exc_valid = 1; exc_is_eret = 0; cp0_epc = 32'h1234_5678;
    @(negedge clk);
    total++;
    if (flush !== 1'b0 || stall !== 6'b000000) begin
      bad++;
      $display("FAIL exc_capture: flush=%b stall=%b want 0/000000", flush, stall);
    end
    next_cycle();
    idle_inputs();
    exe_is_div = 1;
    @(negedge clk);
    total++;
    if (flush !== 1'b1 || flush_pc !== 32'hBFC0_0380 || stall !== 6'b000000 || div_start !== 1'b0) begin
      bad++;
      $display("FAIL exc_flush: flush=%b pc=%h stall=%b start=%b want 1/bfc00380/000000/0",
               flush, flush_pc, stall, div_start);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if (flush !== 1'b0 || flush_pc !== 32'h0) begin
      bad++;
      $display("FAIL exc_after: flush=%b pc=%h want 0/00000000", flush, flush_pc);
    end
  endtask

  task automatic test_exc_wait();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      stallreq_mem = (c < 3);
      exc_valid    = (c < 2);
      exc_is_eret  = (c == 0);
      cp0_epc      = (c == 0) ? 32'h8000_1234 : 32'hDEAD_0000;
      @(negedge clk);
      total++;
      if (c < 4) begin
        if (stall !== 6'b011111 || flush !== 1'b0) begin
          bad++;
          $display("FAIL exc_wait[%0d]: stall=%b flush=%b want 011111/0", c, stall, flush);
        end
      end else if (c == 4) begin
        if (flush !== 1'b1 || flush_pc !== 32'h8000_1234 || stall !== 6'b000000) begin
          bad++;
          $display("FAIL eret_flush: flush=%b pc=%h stall=%b want 1/80001234/000000",
                   flush, flush_pc, stall);
        end
      end else begin
        if (flush !== 1'b0) begin
          bad++;
          $display("FAIL eret_single: flush=%b want 0", flush);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_div_cancel();
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      idle_inputs();
      exe_is_div = (c <= 4) || (c >= 7 && c <= 8);
      exc_valid  = (c == 4);
      div_ready  = (c == 8);
      @(negedge clk);
      total++;
      case (c)
        0: if (div_start !== 1'b1) begin
             bad++; $display("FAIL cancel_launch: start=%b want 1", div_start);
           end
        4: if (div_cancel !== 1'b1 || div_start !== 1'b0 || stall !== 6'b001111) begin
             bad++;
             $display("FAIL cancel_pulse: cancel=%b start=%b stall=%b want 1/0/001111",
                      div_cancel, div_start, stall);
           end
        5: if (flush !== 1'b1 || div_cancel !== 1'b0 || div_start !== 1'b0) begin
             bad++;
             $display("FAIL cancel_flush: flush=%b cancel=%b start=%b want 1/0/0",
                      flush, div_cancel, div_start);
           end
        7: if (div_start !== 1'b1) begin
             bad++; $display("FAIL cancel_fresh: start=%b want 1", div_start);
           end
        8: if (stall !== 6'b000000) begin
             bad++; $display("FAIL cancel_ready: stall=%b want 000000", stall);
           end
        default: if (div_start !== 1'b0 || div_cancel !== 1'b0) begin
             bad++;
             $display("FAIL cancel_quiet[%0d]: start=%b cancel=%b want 0/0", c, div_start, div_cancel);
           end
      endcase
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    // exception together with div_ready: no cancel, flush follows
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      idle_inputs();
      exe_is_div = (c <= 2);
      exc_valid  = (c == 2);
      div_ready  = (c == 2);
      @(negedge clk);
      total++;
      if (c == 2 && (div_cancel !== 1'b0 || div_start !== 1'b0)) begin
        bad++; $display("FAIL exc_ready: cancel=%b start=%b want 0/0", div_cancel, div_start);
      end else if (c == 3 && flush !== 1'b1) begin
        bad++; $display("FAIL exc_ready_flush: flush=%b want 1", flush);
      end else if (c < 2 && c != 0 && div_start !== 1'b0) begin
        bad++; $display("FAIL exc_ready_start[%0d]: start=%b want 0", c, div_start);
      end
    end
    // exception together with a fresh DIV in IDLE: no launch
    next_cycle();
    idle_inputs();
    exe_is_div = 1; exc_valid = 1;
    @(negedge clk);
    total++;
    if (div_start !== 1'b0) begin
      bad++; $display("FAIL exc_vs_start: start=%b want 0", div_start);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if (flush !== 1'b1 || flush_pc !== 32'hBFC0_0380) begin
      bad++; $display("FAIL exc_vs_start_flush: flush=%b pc=%h want 1/bfc00380", flush, flush_pc);
    end
  endtask

  task automatic test_reset_mid_div();
    next_cycle();
    idle_inputs();
    exe_is_div = 1;
    repeat (3) next_cycle();
    rst_n = 0;
    @(negedge clk);
    total++;
    if (stall !== 6'b000000 || div_start !== 1'b0 || div_cancel !== 1'b0 ||
        flush !== 1'b0 || flush_pc !== 32'h0) begin
      bad++;
      $display("FAIL mid_div_reset: stall=%b start=%b cancel=%b flush=%b pc=%h want all zero",
               stall, div_start, div_cancel, flush, flush_pc);
    end
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (div_start !== 1'b1 || stall !== 6'b001111) begin
      bad++;
      $display("FAIL mid_div_idle: start=%b stall=%b want 1/001111", div_start, stall);
    end
    next_cycle();
    idle_inputs();
    rst_n = 0;
    next_cycle();
    rst_n = 1;
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== 32'd0) begin
      bad++; $display("FAIL perf_reset: cnt=%0d want 0", perf_stall_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      stallreq_if = 1;
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== 32'd5) begin
      bad++; $display("FAIL perf_count: cnt=%0d want 5", perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_stall_prio();
    test_div();
    test_exc_vector();
    test_exc_wait();
    test_div_cancel();
    test_simultaneous();
    test_reset_mid_div();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
